// File: rtl/game_sound_player.sv
// game_sound_player: edge-triggered 4-note square-wave melody sequencer
// (win / lose jingles) between the game FSM and the audio pin.
module game_sound_player #(
  parameter int unsigned NOTE_TICKS = 12_500_000,
  parameter int unsigned GAP_TICKS  = 2_500_000,
  parameter int unsigned TONE_SHIFT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable_sound,
  input  logic [9:0] sound_freq,
  output logic       audio_out,
  output logic       busy,
  output logic       done,
  output logic [1:0] note_idx
);

  localparam int unsigned DIV_W = 16;
  localparam int unsigned CNT_W = 32;

  // Half-period table in clocks at 50 MHz, scaled by TONE_SHIFT and clamped to 1
  localparam int unsigned RAW_C5 = 32'd47778 >> TONE_SHIFT;
  localparam int unsigned RAW_E5 = 32'd37922 >> TONE_SHIFT;
  localparam int unsigned RAW_G5 = 32'd31888 >> TONE_SHIFT;
  localparam int unsigned RAW_C6 = 32'd23889 >> TONE_SHIFT;
  localparam logic [DIV_W-1:0] HP_C5 = (RAW_C5 == 0) ? DIV_W'(1) : DIV_W'(RAW_C5);
  localparam logic [DIV_W-1:0] HP_E5 = (RAW_E5 == 0) ? DIV_W'(1) : DIV_W'(RAW_E5);
  localparam logic [DIV_W-1:0] HP_G5 = (RAW_G5 == 0) ? DIV_W'(1) : DIV_W'(RAW_G5);
  localparam logic [DIV_W-1:0] HP_C6 = (RAW_C6 == 0) ? DIV_W'(1) : DIV_W'(RAW_C6);

  localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TONE = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_en_d;
  logic             r_melody;   // 1 = win, 0 = lose
  logic [1:0]       r_note_idx;
  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_dur;
  logic             r_audio;
  logic             r_busy;
  logic             r_done;

  logic             w_start;
  logic [1:0]       w_tone_sel;
  logic [DIV_W-1:0] w_hp;

  // Valid rising edge of the play request
  assign w_start = enable_sound & ~r_en_d & (sound_freq < 10'd2);

  // Lose jingle is the win jingle played backwards
  assign w_tone_sel = r_melody ? r_note_idx : ~r_note_idx;

  // Half-period of the current note (ascending C5 E5 G5 C6)
  always_comb begin
    w_hp = HP_C5;
    case (w_tone_sel)
      2'd0:    w_hp = HP_C5;
      2'd1:    w_hp = HP_E5;
      2'd2:    w_hp = HP_G5;
      default: w_hp = HP_C6;
    endcase
  end

  // Sequencer: trigger/retrigger, tone divider, note and gap timing
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_en_d     <= 1'b0;
      r_melody   <= 1'b0;
      r_note_idx <= 2'd0;
      r_div      <= '0;
      r_dur      <= '0;
      r_audio    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_en_d <= enable_sound;
      r_done <= 1'b0;
      if (w_start) begin
        r_state    <= S_TONE;
        r_melody   <= sound_freq[0];
        r_note_idx <= 2'd0;
        r_div      <= '0;
        r_dur      <= '0;
        r_audio    <= 1'b0;
        r_busy     <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_audio <= 1'b0;
            r_busy  <= 1'b0;
          end
          S_TONE: begin
            if (r_dur == NOTE_LAST) begin
              r_state <= S_GAP;
              r_dur   <= '0;
              r_div   <= '0;
              r_audio <= 1'b0;
            end else begin
              r_dur <= r_dur + CNT_W'(1);
              if (r_div == w_hp - DIV_W'(1)) begin
                r_div   <= '0;
                r_audio <= ~r_audio;
              end else begin
                r_div <= r_div + DIV_W'(1);
              end
            end
          end
          S_GAP: begin
            if (r_dur == GAP_LAST) begin
              r_dur <= '0;
              r_div <= '0;
              if (r_note_idx == 2'd3) begin
                r_state    <= S_IDLE;
                r_note_idx <= 2'd0;
                r_busy     <= 1'b0;
                r_done     <= 1'b1;
              end else begin
                r_state    <= S_TONE;
                r_note_idx <= r_note_idx + 2'd1;
              end
            end else begin
              r_dur <= r_dur + CNT_W'(1);
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_audio <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign audio_out = r_audio;
  assign busy      = r_busy;
  assign done      = r_done;
  assign note_idx  = r_note_idx;

endmodule

// File: tb/tb_game_sound_player.sv
// Scoreboard bench for game_sound_player: a closed-form timing model predicts
// every cycle's outputs; a monitor compares them after each clock edge.
module tb_game_sound_player;

  localparam int unsigned NT       = 40;
  localparam int unsigned GT       = 8;
  localparam int unsigned TS       = 12;
  localparam int          SLOT     = NT + GT;
  localparam int          MEL_LEN  = 4 * SLOT;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable_sound;
  logic [9:0] sound_freq;
  logic       audio_out;
  logic       busy;
  logic       done;
  logic [1:0] note_idx;

  typedef struct packed {
    logic       audio;
    logic       busy;
    logic       done;
    logic [1:0] note;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference model state: only the start cycle and melody of the active tune
  bit   m_active  = 1'b0;
  bit   m_en_prev = 1'b0;
  int   m_t0      = 0;
  int   m_mel     = 0;
  int unsigned tone_entry[4] = '{47778, 37922, 31888, 23889};  // C5 E5 G5 C6
  int   win_seq[4]  = '{0, 1, 2, 3};
  int   lose_seq[4] = '{3, 2, 1, 0};
  int   held = 0;

  always #5 clk = ~clk;

  game_sound_player #(
    .NOTE_TICKS(NT),
    .GAP_TICKS (GT),
    .TONE_SHIFT(TS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable_sound(enable_sound),
    .sound_freq  (sound_freq),
    .audio_out   (audio_out),
    .busy        (busy),
    .done        (done),
    .note_idx    (note_idx)
  );

  // Drive one cycle of inputs and push the outputs expected after that edge
  task automatic step(input bit rst, input bit en, input logic [9:0] f);
    exp_t e;
    int   d, k, o, hp, tone;
    reset        = rst;
    enable_sound = en;
    sound_freq   = f;
    e = '0;
    if (rst) begin
      m_active  = 1'b0;
      m_en_prev = 1'b0;
    end else begin
      if (en && !m_en_prev && f < 10'd2) begin
        m_active = 1'b1;
        m_t0     = cyc;
        m_mel    = int'(f);
      end
      m_en_prev = en;
      if (m_active) begin
        d = cyc - m_t0;
        if (d == MEL_LEN) begin
          e.done   = 1'b1;
          m_active = 1'b0;
        end else begin
          k    = d / SLOT;
          o    = d % SLOT;
          tone = (m_mel == 1) ? win_seq[k] : lose_seq[k];
          hp   = int'(tone_entry[tone] >> TS);
          if (hp == 0) hp = 1;
          e.busy = 1'b1;
          e.note = 2'(k);
          if (o < int'(NT)) e.audio = ((o / hp) % 2) == 1;
        end
      end
    end
    sb_q.push_back(e);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit rnd_freq = 1'b0);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, rnd_freq ? 10'($urandom) : 10'd0);
  endtask

  // Monitor: compare DUT outputs shortly after every active edge
  initial begin
    exp_t e, got;
    int   mcyc;
    mcyc = 0;
    forever begin
      @(posedge clk);
      #1;
      got = {audio_out, busy, done, note_idx};
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty cycle %0d: no expectation queued", mcyc);
      end else begin
        e = sb_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL outputs cycle %0d: got audio=%b busy=%b done=%b note=%0d, expected audio=%b busy=%b done=%b note=%0d",
                   mcyc, got.audio, got.busy, got.done, got.note,
                   e.audio, e.busy, e.done, e.note);
        end
      end
      mcyc++;
    end
  end

  // Stimulus: directed scenarios, then randomized traffic
  initial begin
    // Reset with request held high; melody must start right at release
    step(1'b1, 1'b1, 10'd1);
    step(1'b1, 1'b1, 10'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 10'd1);
    idle(200);

    // Win, single-cycle pulse
    step(1'b0, 1'b1, 10'd1);
    idle(200);

    // Lose, request held 5 cycles, select wiggling afterwards
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 10'd0);
    idle(195, 1'b1);

    // Retrigger at T+100 with the lose melody
    step(1'b0, 1'b1, 10'd1);
    idle(99);
    step(1'b0, 1'b1, 10'd0);
    idle(300);

    // Retrigger exactly on the end-of-melody cycle
    step(1'b0, 1'b1, 10'd1);
    idle(191);
    step(1'b0, 1'b1, 10'd1);
    idle(200);

    // Invalid select while idle and while playing
    step(1'b0, 1'b1, 10'd7);
    idle(5);
    step(1'b0, 1'b1, 10'd1);
    idle(30);
    step(1'b0, 1'b1, 10'd7);
    idle(200, 1'b1);

    // Reset mid-play
    step(1'b0, 1'b1, 10'd0);
    idle(59);
    step(1'b1, 1'b0, 10'd0);
    idle(200);

    // Random traffic: sparse pulses of random length, random selects, rare resets
    for (int i = 0; i < 4000; i++) begin
      bit          r_rst, r_en;
      logic [9:0]  r_f;
      r_rst = ($urandom_range(0, 499) == 0);
      if (held > 0) begin
        held--;
      end else if ($urandom_range(0, 89) == 0) begin
        held = $urandom_range(1, 4);
      end
      r_en = (held > 0);
      case ($urandom_range(0, 3))
        0:       r_f = 10'($urandom);
        1:       r_f = 10'd0;
        default: r_f = 10'd1;
      endcase
      step(r_rst, r_en, r_f);
    end
    idle(10);

    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_sound_player.md
# game_sound_player

Tone sequencer that consumes the game controller's sound request (`enable_sound`, `sound_freq`) and turns it into an audible square wave. A rising edge of `enable_sound` starts a fixed 4-note melody selected by `sound_freq` (0 = lose jingle, 1 = win jingle). The melody plays autonomously after the trigger, even though the request is only a few cycles long. Sits between the game FSM and the board audio pin/codec driver.

## Interface
- `NOTE_TICKS`, default 12_500_000: cycles each note sounds (250 ms @ 50 MHz); legal range is ≥ 1.
- `GAP_TICKS`, default 2_500_000: silent cycles after each note; legal range is ≥ 1.
- `TONE_SHIFT`, default 0: right-shift applied to every half-period table entry; used for simulation speed-up.

- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `enable_sound`  in  1  play request; only its rising edge matters.
- `sound_freq`  in  10  melody select, sampled on the trigger edge: 0 = lose, 1 = win, ≥ 2 = invalid.
- `audio_out`  out  1  square-wave output; 0 when silent.
- `busy`  out  1  high while a melody is playing (TONE or GAP state).
- `done`  out  1  one-cycle pulse when a melody completes normally.
- `note_idx`  out  2  index (0..3) of the current note; 0 when idle.

## Operation
- Edge detect: register `enable_sound` into `en_d`. A trigger is `enable_sound & ~en_d`. After reset, `en_d` = 0, so `enable_sound` already high when reset releases counts as an edge.
- A trigger with `sound_freq` ≥ 2 is ignored: no state change, and any melody already playing is not disturbed.
- Melody table, in half-period clocks at 50 MHz:
  - C5 = 47778, E5 = 37922, G5 = 31888, C6 = 23889.
  - Win melody: C5, E5, G5, C6.
  - Lose melody: C6, G5, E5, C5.
- Effective half-period `hp` = entry >> `TONE_SHIFT`. If that result is 0, `hp` = 1. The divider counter is 16 bits.
- States:
  - **IDLE**: `audio_out` = 0, `busy` = 0. A valid trigger latches the melody ID, sets `note_idx` = 0, clears the divider and duration counters, and moves to TONE.
  - **TONE**: the divider counts 0..hp-1. At hp-1 it toggles `audio_out` and wraps to 0. The duration counter counts NOTE_TICKS cycles, then the block forces `audio_out` = 0 and moves to GAP.
  - **GAP**: `audio_out` = 0 for GAP_TICKS cycles.
    - If `note_idx` < 3: increment `note_idx`, clear the counters, go to TONE.
    - If `note_idx` = 3: go to IDLE and assert `done` for that single transition cycle.
- Retrigger while `busy` (valid select): restart immediately.
  - Latch the new melody, set `note_idx` = 0, clear the counters, force `audio_out` = 0 on the next cycle, go to TONE.
  - The aborted melody produces no `done` pulse.
  - A retrigger takes priority over a simultaneous end of melody; `done` is suppressed in that case.
- `sound_freq` changing mid-melody has no effect; only the value latched at the trigger is used.

## Timing
- Reset (synchronous, checked at a `clk` edge) forces the following on the next cycle, including mid-melody:
  - state IDLE, `audio_out` = 0, `busy` = 0, `done` = 0;
  - `note_idx` = 0, all counters 0, `en_d` = 0.
- Start latency, with the trigger edge sampled at cycle T:
  - `busy` = 1 from T+1; first TONE cycle is T+1.
  - `audio_out` first rises at T+1+hp, then toggles every hp cycles.
- Each note occupies exactly NOTE_TICKS cycles in TONE plus GAP_TICKS cycles in GAP.
- Note k starts at T+1+k·(NOTE_TICKS+GAP_TICKS).
- Completion: `done` = 1 and `busy` = 0 at cycle T+1+4·(NOTE_TICKS+GAP_TICKS).
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
Settings for all tests: `TONE_SHIFT`=12 (hp: C5 11, E5 9, G5 7, C6 5), `NOTE_TICKS`=40, `GAP_TICKS`=8.
- **Reset:** assert `reset` for 2 cycles with `enable_sound`=1 → all outputs 0.
  - After release with `enable_sound` still 1 and `sound_freq`=1: exactly one melody starts, `busy`=1 the cycle after release.
- **Win:** 1-cycle `enable_sound` pulse at T with `sound_freq`=1.
  - `busy`=1 at T+1; `audio_out` rises at T+12 and toggles every 11 cycles through T+40.
  - `note_idx`=1 at T+49 with 9-cycle toggles.
  - `done` pulse at T+193, `busy`=0 at T+193.
- **Lose with held request:** `sound_freq`=0, `enable_sound` held high 5 cycles from T.
  - Only one start; first note hp=5 (rise at T+6); last note hp=11.
  - `done` at T+193.
- **Retrigger:** start the win melody at T, then a lose edge at T+100 (`note_idx`=2).
  - `audio_out`=0 and `note_idx`=0 at T+101; hp=5 tone follows.
  - No `done` at T+193; `done` at T+100+193.
- **Invalid select:** edge with `sound_freq`=7 while idle → `busy` stays 0.
  - Same edge during a melody → the melody continues unchanged.
- **Reset mid-play:** start a melody, pulse `reset` at T+60 → all outputs 0 at T+61, no `done`.
